rf_wb_arbiter: RTL and testbench

- Shares the single register-file write port between the in-order pipeline write-back stage and the multi-cycle multiply/divide unit (MDU).
- Keeps a per-register busy scoreboard for outstanding MDU destinations and generates the decode stall.
- Buffers MDU results in a small FIFO.
- Sits between WB/MDU and the register file write port.

---
 rtl/rf_wb_arbiter.sv | 142 ++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter between the pipeline WB stage and the MDU.
// Queues MDU results, tracks outstanding MDU destinations and forces a drain when the queue head starves.
module rf_wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int QDEPTH     = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wb_we,
  input  logic [ADDR_W-1:0]      wb_rw,
  input  logic [DATA_W-1:0]      wb_rd,
  input  logic [ADDR_W-1:0]      dec_ra,
  input  logic [ADDR_W-1:0]      dec_rb,
  input  logic [ADDR_W-1:0]      dec_rw,
  input  logic                   dec_we,
  input  logic                   mdu_issue,
  input  logic                   mdu_valid,
  input  logic [ADDR_W-1:0]      mdu_rw,
  input  logic [DATA_W-1:0]      mdu_rd,
  output logic                   mdu_ready,
  output logic                   rf_we,
  output logic [ADDR_W-1:0]      rf_rw,
  output logic [DATA_W-1:0]      rf_rd,
  output logic                   stall,
  output logic                   wb_hold,
  output logic [(2**ADDR_W)-1:0] busy
);

  localparam int NREG  = 2**ADDR_W;
  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = $clog2(QDEPTH + 1);
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  logic [ADDR_W-1:0] q_rw [QDEPTH];
  logic [DATA_W-1:0] q_rd [QDEPTH];

  logic [PTR_W-1:0] head_reg;
  logic [PTR_W-1:0] tail_reg;
  logic [CNT_W-1:0] count_reg;
  logic [STV_W-1:0] starve_reg;
  logic [STV_W-1:0] starve_next;
  logic             wb_hold_reg;
  logic [NREG-1:0]  busy_reg;
  logic [NREG-1:0]  set_vec;
  logic [NREG-1:0]  clr_vec;

  logic              non_empty;
  logic              wb_grant;
  logic              drain;
  logic              push;
  logic              issue_set;
  logic [ADDR_W-1:0] head_rw;
  logic [DATA_W-1:0] head_rd;

  assign non_empty = (count_reg != '0);
  assign head_rw   = q_rw[head_reg];
  assign head_rd   = q_rd[head_reg];
  assign wb_grant  = wb_we && (wb_rw != '0) && !wb_hold_reg;
  assign drain     = !reset && !wb_grant && non_empty;
  assign mdu_ready = (count_reg != CNT_W'(QDEPTH));
  // Results for r0 complete the handshake but are never stored.
  assign push      = mdu_valid && mdu_ready && (mdu_rw != '0);

  assign stall     = busy_reg[dec_ra] | busy_reg[dec_rb] |
                     ((dec_we | mdu_issue) & busy_reg[dec_rw]);
  assign issue_set = mdu_issue && !stall && (dec_rw != '0);

  assign busy    = busy_reg;
  assign wb_hold = wb_hold_reg;

  always_comb begin
    rf_we = 1'b0;
    rf_rw = '0;
    rf_rd = '0;
    if (!reset) begin
      if (wb_grant) begin
        rf_we = 1'b1;
        rf_rw = wb_rw;
        rf_rd = wb_rd;
      end else if (non_empty) begin
        rf_we = 1'b1;
        rf_rw = head_rw;
        rf_rd = head_rd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_rw[tail_reg] <= mdu_rw;
      q_rd[tail_reg] <= mdu_rd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (drain) head_reg <= head_reg + PTR_W'(1);
      if (push)  tail_reg <= tail_reg + PTR_W'(1);
      if (push && !drain)
        count_reg <= count_reg + CNT_W'(1);
      else if (drain && !push)
        count_reg <= count_reg - CNT_W'(1);
    end
  end

  // The hold pulse forces a drain on the following cycle, which clears the counter again.
  assign starve_next = (non_empty && !drain) ? starve_reg + STV_W'(1) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_reg  <= '0;
      wb_hold_reg <= 1'b0;
    end else begin
      starve_reg  <= starve_next;
      wb_hold_reg <= (starve_next == STV_W'(STARVE_MAX - 1));
    end
  end

  assign set_vec[0] = 1'b0;
  assign clr_vec[0] = 1'b0;

  generate
    for (genvar gi = 1; gi < NREG; gi++) begin : g_busy
      assign set_vec[gi] = issue_set && (dec_rw == ADDR_W'(gi));
      assign clr_vec[gi] = drain && (head_rw == ADDR_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      busy_reg <= '0;
    else
      busy_reg <= (busy_reg & ~clr_vec) | set_vec;
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Testbench for rf_wb_arbiter: directed scenarios with literal expectations, then randomized traffic,
// all checked every cycle against a queue-based behavioural model.
module tb_rf_wb_arbiter;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 5;
  localparam int QDEPTH     = 2;
  localparam int STARVE_MAX = 4;
  localparam int NREG       = 2**ADDR_W;

  logic              clk;
  logic              reset;
  logic              wb_we;
  logic [ADDR_W-1:0] wb_rw;
  logic [DATA_W-1:0] wb_rd;
  logic [ADDR_W-1:0] dec_ra;
  logic [ADDR_W-1:0] dec_rb;
  logic [ADDR_W-1:0] dec_rw;
  logic              dec_we;
  logic              mdu_issue;
  logic              mdu_valid;
  logic [ADDR_W-1:0] mdu_rw;
  logic [DATA_W-1:0] mdu_rd;
  logic              mdu_ready;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_rw;
  logic [DATA_W-1:0] rf_rd;
  logic              stall;
  logic              wb_hold;
  logic [NREG-1:0]   busy;

  int n_cmp = 0;
  int n_err = 0;

  rf_wb_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .QDEPTH(QDEPTH), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .reset(reset),
    .wb_we(wb_we), .wb_rw(wb_rw), .wb_rd(wb_rd),
    .dec_ra(dec_ra), .dec_rb(dec_rb), .dec_rw(dec_rw), .dec_we(dec_we),
    .mdu_issue(mdu_issue), .mdu_valid(mdu_valid), .mdu_rw(mdu_rw), .mdu_rd(mdu_rd),
    .mdu_ready(mdu_ready), .rf_we(rf_we), .rf_rw(rf_rw), .rf_rd(rf_rd),
    .stall(stall), .wb_hold(wb_hold), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: result queue, busy set, and a count of cycles the head has been passed over.
  typedef struct {
    logic [ADDR_W-1:0] rw;
    logic [DATA_W-1:0] rd;
  } ent_t;

  ent_t           m_q[$];
  bit [NREG-1:0]  m_busy = '0;
  int             m_wait = 0;
  bit             m_hold = 1'b0;

  function automatic bit m_stall();
    return m_busy[dec_ra] | m_busy[dec_rb] | ((dec_we | mdu_issue) & m_busy[dec_rw]);
  endfunction

  initial begin : compare
    bit   e_grant;
    bit   e_we;
    bit   drained;
    bit   stl;
    int   n;
    ent_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("reset_rf_we", rf_we, 0);
        chk("reset_busy", busy, 0);
        chk("reset_mdu_ready", mdu_ready, 1);
        chk("reset_wb_hold", wb_hold, 0);
      end else begin
        e_grant = wb_we && (wb_rw != 0) && !m_hold;
        e_we    = e_grant || (m_q.size() != 0);
        chk("rf_we", rf_we, e_we);
        if (e_we) begin
          chk("rf_rw", rf_rw, e_grant ? wb_rw : m_q[0].rw);
          chk("rf_rd", rf_rd, e_grant ? wb_rd : m_q[0].rd);
        end
        chk("mdu_ready", mdu_ready, m_q.size() != QDEPTH);
        chk("stall", stall, m_stall());
        chk("wb_hold", wb_hold, m_hold);
        chk("busy", busy, m_busy);
      end
      @(posedge clk);
      if (reset) begin
        m_q.delete();
        m_busy = '0;
        m_wait = 0;
        m_hold = 1'b0;
      end else begin
        n       = m_q.size();
        e_grant = wb_we && (wb_rw != 0) && !m_hold;
        drained = !e_grant && (n > 0);
        stl     = m_stall();
        if (drained) begin
          m_busy[m_q[0].rw] = 1'b0;
          m_q.delete(0);
        end
        if (mdu_valid && (n != QDEPTH) && (mdu_rw != 0)) begin
          e.rw = mdu_rw;
          e.rd = mdu_rd;
          m_q.push_back(e);
        end
        if (mdu_issue && !stl && (dec_rw != 0)) m_busy[dec_rw] = 1'b1;
        if (n > 0 && !drained) m_wait++;
        else m_wait = 0;
        m_hold = (m_wait == STARVE_MAX - 1);
      end
    end
  end

  task automatic idle();
    wb_we = 0; wb_rw = 0; wb_rd = 0;
    dec_ra = 0; dec_rb = 0; dec_rw = 0; dec_we = 0; mdu_issue = 0;
    mdu_valid = 0; mdu_rw = 0; mdu_rd = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [ADDR_W-1:0] iss_q[$];

  initial begin : stimulus
    bit acc;
    bit hold_seen;
    bit rst_seen;
    reset = 1'b1;
    idle();
    wb_we = 1; wb_rw = 3; wb_rd = 32'h33;
    #2;
    chk("lit_reset_rf_we", rf_we, 0);
    chk("lit_reset_ready", mdu_ready, 1);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    idle();

    // Issue r5, dependent read stalls until the drain cycle has passed
    step(); idle(); dec_rw = 5; dec_we = 1; mdu_issue = 1; #1;
    chk("lit_a_stall0", stall, 0);
    step(); idle(); dec_ra = 5; #1;
    chk("lit_a_stall1", stall, 1);
    chk("lit_a_busy5", busy[5], 1);
    step(); idle(); dec_ra = 5; mdu_valid = 1; mdu_rw = 5; mdu_rd = 32'h1234; #1;
    chk("lit_a_ready", mdu_ready, 1);
    step(); idle(); dec_ra = 5; #1;
    chk("lit_a_we", rf_we, 1);
    chk("lit_a_rw", rf_rw, 5);
    chk("lit_a_rd", rf_rd, 32'h1234);
    chk("lit_a_stall_drain", stall, 1);
    step(); idle(); dec_ra = 5; #1;
    chk("lit_a_stall_after", stall, 0);
    chk("lit_a_busy_after", busy[5], 0);

    // WB beats a queued result; the result follows on the next idle WB cycle
    step(); idle(); dec_rw = 7; dec_we = 1; mdu_issue = 1;
    step(); idle(); mdu_valid = 1; mdu_rw = 7; mdu_rd = 32'hBB;
    step(); idle(); wb_we = 1; wb_rw = 3; wb_rd = 32'hAA; #1;
    chk("lit_b_rw_wb", rf_rw, 3);
    chk("lit_b_rd_wb", rf_rd, 32'hAA);
    step(); idle(); #1;
    chk("lit_b_rw_q", rf_rw, 7);
    chk("lit_b_rd_q", rf_rd, 32'hBB);

    // Full FIFO under constant WB traffic: backpressure, then one forced-drain pulse
    step(); idle(); wb_we = 1; wb_rw = 1; wb_rd = 32'h11; mdu_valid = 1; mdu_rw = 7; mdu_rd = 32'h77;
    step(); wb_rd = 32'h12; mdu_rw = 8; mdu_rd = 32'h88; #1;
    chk("lit_c_ready1", mdu_ready, 1);
    step(); wb_rd = 32'h13; mdu_rw = 9; mdu_rd = 32'h99; #1;
    chk("lit_c_full", mdu_ready, 0);
    step(); wb_rd = 32'h14; #1;
    chk("lit_c_full2", mdu_ready, 0);
    chk("lit_c_nohold", wb_hold, 0);
    step(); wb_rd = 32'h55; #1;
    chk("lit_c_hold", wb_hold, 1);
    chk("lit_c_hold_rw", rf_rw, 7);
    chk("lit_c_hold_rd", rf_rd, 32'h77);
    step(); #1;
    chk("lit_c_hold_off", wb_hold, 0);
    chk("lit_c_repr_rw", rf_rw, 1);
    chk("lit_c_repr_rd", rf_rd, 32'h55);
    chk("lit_c_ready2", mdu_ready, 1);
    step(); idle(); #1;
    chk("lit_c_rw8", rf_rw, 8);
    step(); idle(); #1;
    chk("lit_c_rw9", rf_rw, 9);
    chk("lit_c_rd9", rf_rd, 32'h99);
    step(); idle(); #1;
    chk("lit_c_empty", rf_we, 0);

    // r0 as MDU destination is neither tracked nor written
    step(); idle(); dec_rw = 0; dec_we = 1; mdu_issue = 1; #1;
    chk("lit_d_stall", stall, 0);
    step(); idle(); mdu_valid = 1; mdu_rw = 0; mdu_rd = 32'hDEAD; #1;
    chk("lit_d_busy", busy, 0);
    step(); idle(); #1;
    chk("lit_d_we", rf_we, 0);
    chk("lit_d_ready", mdu_ready, 1);

    // Simultaneous push and pop at count 1
    step(); idle(); mdu_valid = 1; mdu_rw = 4; mdu_rd = 32'h44;
    step(); idle(); mdu_valid = 1; mdu_rw = 6; mdu_rd = 32'h66; #1;
    chk("lit_e_rw4", rf_rw, 4);
    chk("lit_e_ready", mdu_ready, 1);
    step(); idle(); #1;
    chk("lit_e_rw6", rf_rw, 6);
    chk("lit_e_rd6", rf_rd, 32'h66);
    step(); idle(); #1;
    chk("lit_e_empty", rf_we, 0);

    // Reset with two queued results and r5 busy
    step(); idle(); wb_we = 1; wb_rw = 2; wb_rd = 32'h22;
    dec_rw = 5; dec_we = 1; mdu_issue = 1; mdu_valid = 1; mdu_rw = 10; mdu_rd = 32'hA0;
    step(); dec_rw = 0; dec_we = 0; mdu_issue = 0; mdu_rw = 11; mdu_rd = 32'hB0;
    step(); mdu_valid = 0; #1;
    chk("lit_f_busy5", busy[5], 1);
    chk("lit_f_full", mdu_ready, 0);
    reset = 1'b1; #1;
    chk("lit_f_busy", busy, 0);
    chk("lit_f_ready", mdu_ready, 1);
    chk("lit_f_we", rf_we, 0);
    step(); reset = 1'b0; idle(); #1;
    chk("lit_f_we_after", rf_we, 0);
    repeat (3) begin
      step(); #1;
      chk("lit_f_no_stale", rf_we, 0);
    end

    // Randomized traffic; MDU results return in issue order
    iss_q.delete();
    rst_seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      acc       = mdu_valid && mdu_ready && !reset;
      hold_seen = wb_hold && !reset;
      rst_seen  = reset;
      if (!reset && mdu_issue && !stall) iss_q.push_back(dec_rw);
      @(posedge clk);
      #1;
      if (rst_seen) begin
        reset = 1'b0;
      end else if ($urandom_range(0, 299) == 0) begin
        reset = 1'b1;
        iss_q.delete();
        mdu_valid = 0;
      end
      if (!(hold_seen && wb_we)) begin
        wb_we = ($urandom_range(0, 2) != 0);
        wb_rw = ADDR_W'($urandom_range(0, 7));
        wb_rd = $urandom;
      end
      dec_ra    = ADDR_W'($urandom_range(0, 7));
      dec_rb    = ADDR_W'($urandom_range(0, 7));
      dec_rw    = ADDR_W'($urandom_range(0, 7));
      dec_we    = ($urandom_range(0, 1) != 0);
      mdu_issue = ($urandom_range(0, 3) == 0);
      if (reset) begin
        mdu_valid = 0;
      end else if (!(mdu_valid && !acc)) begin
        if (iss_q.size() != 0 && $urandom_range(0, 1) != 0) begin
          mdu_valid = 1;
          mdu_rw    = iss_q.pop_front();
          mdu_rd    = $urandom;
        end else begin
          mdu_valid = 0;
        end
      end
    end

    step(); idle(); reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
